// File: rtl/frame_align_pkg.sv
// Shared types and default constants for the frame-lane alignment search.
package frame_align_pkg;

    // Alignment search states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } align_state_e;

    localparam logic [7:0]  DEF_FRAME_PATTERN = 8'hF0;
    localparam int unsigned DEF_SETTLE_CYCLES = 32'd8;
    localparam int unsigned DEF_MATCH_COUNT   = 32'd16;
    localparam int unsigned DEF_LOSS_COUNT    = 32'd4;

    // Increment an 8-bit counter, holding at all-ones instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/frame_aligner.sv
// Frame aligner: steps the shared bitslip position until the frame lane shows
// the expected pattern for enough consecutive words, then watches for loss of
// lock and restarts the search when the pattern disappears.
module frame_aligner
    import frame_align_pkg::*;
#(
    parameter int unsigned          DIN_WIDTH     = 8,
    parameter logic [DIN_WIDTH-1:0] FRAME_PATTERN = DEF_FRAME_PATTERN,
    parameter int unsigned          SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned          MATCH_COUNT   = DEF_MATCH_COUNT,
    parameter int unsigned          LOSS_COUNT    = DEF_LOSS_COUNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIN_WIDTH-1:0] frame_din,
    output logic [3:0]           bitslip_count,
    output logic                 locked,
    output logic                 align_busy,
    output logic                 align_fail,
    output logic [7:0]           lock_loss_cnt
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned MW = $clog2(MATCH_COUNT + 1);
    localparam int unsigned LW = $clog2(LOSS_COUNT + 1);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_INC  = SW'(1);
    localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_COUNT - 1);
    localparam logic [MW-1:0] MATCH_INC   = MW'(1);
    localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_COUNT - 1);
    localparam logic [LW-1:0] LOSS_INC    = LW'(1);
    localparam logic [3:0]    SLIP_LAST   = 4'(DIN_WIDTH - 1);

    align_state_e  state_r, state_s;
    logic [3:0]    slip_r, slip_s;
    logic          locked_r, locked_s;
    logic          busy_r, busy_s;
    logic          fail_r, fail_s;
    logic [7:0]    loss_r, loss_s;
    logic [SW-1:0] settle_r, settle_s;
    logic [MW-1:0] match_r, match_s;
    logic [LW-1:0] miss_r, miss_s;
    logic          restart_s;
    logic          match_now_s;

    // Next-state and next-output computation; start overrides every transition
    always_comb begin
        state_s     = state_r;
        slip_s      = slip_r;
        locked_s    = locked_r;
        busy_s      = busy_r;
        fail_s      = fail_r;
        loss_s      = loss_r;
        settle_s    = settle_r;
        match_s     = match_r;
        miss_s      = miss_r;
        restart_s   = 1'b0;
        match_now_s = (frame_din == FRAME_PATTERN);

        case (state_r)
            ST_IDLE: begin
                // wait for start
            end
            ST_SETTLE: begin
                // frame_din is stale while the new slip ripples through the lanes
                if (settle_r == SETTLE_LAST) begin
                    state_s = ST_CHECK;
                    match_s = {MW{1'b0}};
                end else begin
                    settle_s = settle_r + SETTLE_INC;
                end
            end
            ST_CHECK: begin
                if (match_now_s) begin
                    if (match_r == MATCH_LAST) begin
                        state_s  = ST_LOCKED;
                        locked_s = 1'b1;
                        busy_s   = 1'b0;
                        match_s  = {MW{1'b0}};
                        miss_s   = {LW{1'b0}};
                    end else begin
                        match_s = match_r + MATCH_INC;
                    end
                end else if (slip_r < SLIP_LAST) begin
                    state_s  = ST_SETTLE;
                    slip_s   = slip_r + 4'd1;
                    settle_s = {SW{1'b0}};
                    match_s  = {MW{1'b0}};
                end else begin
                    state_s = ST_FAIL;
                    slip_s  = 4'd0;
                    fail_s  = 1'b1;
                    busy_s  = 1'b0;
                    match_s = {MW{1'b0}};
                end
            end
            ST_LOCKED: begin
                if (match_now_s) begin
                    miss_s = {LW{1'b0}};
                end else if (miss_r == LOSS_LAST) begin
                    restart_s = 1'b1;
                    loss_s    = sat_inc8(loss_r);
                end else begin
                    miss_s = miss_r + LOSS_INC;
                end
            end
            ST_FAIL: begin
                // sticky failure until start
            end
            default: begin
                state_s  = ST_IDLE;
                slip_s   = 4'd0;
                locked_s = 1'b0;
                busy_s   = 1'b0;
                settle_s = {SW{1'b0}};
                match_s  = {MW{1'b0}};
                miss_s   = {LW{1'b0}};
            end
        endcase

        // A start request is a restart, never a lock loss
        if (start) begin
            loss_s = loss_r;
        end else begin
            loss_s = loss_s;
        end

        if (start || restart_s) begin
            state_s  = ST_SETTLE;
            slip_s   = 4'd0;
            locked_s = 1'b0;
            busy_s   = 1'b1;
            fail_s   = 1'b0;
            settle_s = {SW{1'b0}};
            match_s  = {MW{1'b0}};
            miss_s   = {LW{1'b0}};
        end else begin
            state_s = state_s;
        end
    end

    // State, counter and registered-output update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            slip_r   <= 4'd0;
            locked_r <= 1'b0;
            busy_r   <= 1'b0;
            fail_r   <= 1'b0;
            loss_r   <= 8'd0;
            settle_r <= {SW{1'b0}};
            match_r  <= {MW{1'b0}};
            miss_r   <= {LW{1'b0}};
        end else begin
            state_r  <= state_s;
            slip_r   <= slip_s;
            locked_r <= locked_s;
            busy_r   <= busy_s;
            fail_r   <= fail_s;
            loss_r   <= loss_s;
            settle_r <= settle_s;
            match_r  <= match_s;
            miss_r   <= miss_s;
        end
    end

    assign bitslip_count = slip_r;
    assign locked        = locked_r;
    assign align_busy    = busy_r;
    assign align_fail    = fail_r;
    assign lock_loss_cnt = loss_r;

endmodule
